// File: rtl/wb_avalon_pkg.sv
// Shared constants for the Avalon/Wishbone burst bridges: cycle types, burst types,
// Avalon response codes and the bridge FSM state encoding.
package wb_avalon_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INC     = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_READ     = 2'd1;
    localparam logic [1:0] ST_WRITE    = 2'd2;

endpackage

// File: rtl/wb_burst_counter.sv
// Burst address/beat tracker: loads a start address and beat count, steps by one
// data word per accepted beat and flags the final beat. Count 0 loads as 1.
module wb_burst_counter #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [AW-1:0]    load_adr,
    input  logic [CNT_W-1:0] load_cnt,
    input  logic             advance,
    output logic [AW-1:0]    adr,
    output logic             last
);

    localparam logic [AW-1:0] STEP = AW'(DW / 8);

    logic [AW-1:0]    adr_q, adr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        adr_d = adr_q;
        cnt_d = cnt_q;
        if (load) begin
            adr_d = load_adr;
            cnt_d = (load_cnt == '0) ? CNT_W'(1) : load_cnt;
        end else if (advance) begin
            // address wraps naturally modulo 2^AW
            adr_d = adr_q + STEP;
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            adr_q <= '0;
            cnt_q <= '0;
        end else begin
            adr_q <= adr_d;
            cnt_q <= cnt_d;
        end
    end

    assign adr  = adr_q;
    assign last = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/avalon_to_wb_burst_bridge.sv
// Avalon-MM burst slave to Wishbone B4 incrementing-burst master, one burst in flight.
// Define AVALON_RESPONSE_EN to add the s_response port (OKAY / SLAVEERROR per beat).
//   state    | meaning
//   ST_IDLE  | waiting for s_read / s_write, command latched on entry to a burst
//   ST_READ  | strobing read beats, data returned one cycle after each ack
//   ST_WRITE | strobing write beats as the Avalon host presents them
module avalon_to_wb_burst_bridge
    import wb_avalon_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int BURST_W = 4
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic [AW-1:0]      s_address,
    input  logic [DW/8-1:0]    s_byteenable,
    input  logic               s_read,
    input  logic               s_write,
    input  logic [DW-1:0]      s_writedata,
    input  logic [BURST_W-1:0] s_burstcount,
    output logic [DW-1:0]      s_readdata,
    output logic               s_readdatavalid,
    output logic               s_waitrequest,
`ifdef AVALON_RESPONSE_EN
    output logic [1:0]         s_response,
`endif
    output logic [AW-1:0]      wbm_adr_o,
    output logic [DW-1:0]      wbm_dat_o,
    output logic [DW/8-1:0]    wbm_sel_o,
    output logic               wbm_we_o,
    output logic               wbm_cyc_o,
    output logic               wbm_stb_o,
    output logic [2:0]         wbm_cti_o,
    output logic [1:0]         wbm_bte_o,
    input  logic [DW-1:0]      wbm_dat_i,
    input  logic               wbm_ack_i,
    input  logic               wbm_err_i,
    input  logic               wbm_rty_i
);

    localparam int SW = DW / 8;

    logic [1:0]    state_q, state_d;
    logic [SW-1:0] sel_q, sel_d;
    logic          rdv_q, rdv_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          load, advance, last, beat_done;
    logic [AW-1:0] adr;
    logic          unused_rty;

    assign unused_rty = wbm_rty_i;
    assign beat_done  = wbm_ack_i | wbm_err_i;

    wb_burst_counter #(.AW(AW), .DW(DW), .CNT_W(BURST_W)) u_counter (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .load     (load),
        .load_adr (s_address),
        .load_cnt (s_burstcount),
        .advance  (advance),
        .adr      (adr),
        .last     (last)
    );

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        rdv_d         = 1'b0;
        rdata_d       = rdata_q;
        load          = 1'b0;
        advance       = 1'b0;
        wbm_cyc_o     = 1'b0;
        wbm_stb_o     = 1'b0;
        wbm_we_o      = 1'b0;
        wbm_cti_o     = CTI_CLASSIC;
        wbm_sel_o     = '0;
        s_waitrequest = 1'b1;
        case (state_q)
            ST_IDLE: begin
                // read wins a simultaneous request; write beats are taken in ST_WRITE
                if (s_read) begin
                    load          = 1'b1;
                    sel_d         = s_byteenable;
                    state_d       = ST_READ;
                    s_waitrequest = 1'b0;
                end else if (s_write) begin
                    load    = 1'b1;
                    sel_d   = s_byteenable;
                    state_d = ST_WRITE;
                end
            end
            ST_READ: begin
                wbm_cyc_o = 1'b1;
                wbm_stb_o = 1'b1;
                wbm_cti_o = last ? CTI_EOB : CTI_INC;
                wbm_sel_o = sel_q;
                if (beat_done) begin
                    advance = 1'b1;
                    rdv_d   = 1'b1;
                    rdata_d = wbm_dat_i;
                    if (last) state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                wbm_cyc_o     = 1'b1;
                wbm_we_o      = 1'b1;
                wbm_stb_o     = s_write;
                wbm_cti_o     = last ? CTI_EOB : CTI_INC;
                wbm_sel_o     = s_byteenable;
                s_waitrequest = !beat_done;
                if (s_write && beat_done) begin
                    advance = 1'b1;
                    if (last) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (wb_rst_i) s_waitrequest = 1'b1;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            rdv_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            rdv_q   <= rdv_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef AVALON_RESPONSE_EN
    logic [1:0] resp_q, resp_d;

    always_comb begin
        resp_d = resp_q;
        if ((state_q == ST_READ && beat_done) || (state_q == ST_WRITE && s_write && beat_done))
            resp_d = wbm_err_i ? RESP_SLVERR : RESP_OKAY;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) resp_q <= RESP_OKAY;
        else          resp_q <= resp_d;
    end

    assign s_response = resp_q;
`endif

    assign wbm_adr_o       = adr;
    assign wbm_dat_o       = s_writedata;
    assign wbm_bte_o       = BTE_LINEAR;
    assign s_readdata      = rdata_q;
    assign s_readdatavalid = rdv_q;

endmodule
